i2c_master_ctrl: RTL

//  Command-driven I2C master byte engine; single master, multi slave. Sits behind the Avalon slave

---
 rtl/i2c_master_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// Command-driven I2C master byte engine: START, 8 data bits, ACK and STOP sequenced on a
// quarter-SCL-period tick, with open-drain line control and optional slave clock stretching.
module i2c_master_ctrl #(
    parameter int DIV_W      = 16,
    parameter int STRETCH_EN = 1,
    parameter int STRETCH_TO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd,
    input  logic [7:0]       cmd_wdata,
    input  logic             cmd_nack,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic             rsp_nack,
    output logic             bus_err,
    output logic             busy,
    input  logic             sda_i,
    input  logic             scl_i,
    output logic             sda_oe,
    output logic             scl_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [31:0] STRETCH_LIM = 32'(STRETCH_TO);

    state_t           state_reg, state_next;
    logic [1:0]       phase_reg, phase_next;
    logic [2:0]       bit_reg, bit_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [3:0]       cmd_reg, cmd_next;
    logic [7:0]       wdata_reg, wdata_next;
    logic             nack_reg, nack_next;
    logic [7:0]       rsp_rdata_reg, rdata_next;
    logic             rsp_nack_reg, rsp_nack_next;
    logic             bus_err_reg, bus_err_next;
    logic             busy_reg, busy_next;
    logic             sda_oe_reg, sda_oe_next;
    logic             scl_oe_reg, scl_oe_next;
    logic [31:0]      stretch_reg, stretch_next;
    logic [1:0]       sync1_reg, sync2_reg;

    logic sda_sync, scl_sync;
    logic active, hold, tick, timeout, illegal;

    assign sda_sync = sync2_reg[0];
    assign scl_sync = sync2_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= '0;
            bit_reg       <= '0;
            cnt_reg       <= '0;
            div_reg       <= '0;
            cmd_reg       <= '0;
            wdata_reg     <= '0;
            nack_reg      <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_nack_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            sda_oe_reg    <= 1'b0;
            scl_oe_reg    <= 1'b0;
            stretch_reg   <= '0;
            sync1_reg     <= 2'b11;
            sync2_reg     <= 2'b11;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            bit_reg       <= bit_next;
            cnt_reg       <= cnt_next;
            div_reg       <= div_next;
            cmd_reg       <= cmd_next;
            wdata_reg     <= wdata_next;
            nack_reg      <= nack_next;
            rsp_rdata_reg <= rdata_next;
            rsp_nack_reg  <= rsp_nack_next;
            bus_err_reg   <= bus_err_next;
            busy_reg      <= busy_next;
            sda_oe_reg    <= sda_oe_next;
            scl_oe_reg    <= scl_oe_next;
            stretch_reg   <= stretch_next;
            sync1_reg     <= {scl_i, sda_i};
            sync2_reg     <= sync1_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        bit_next      = bit_reg;
        cnt_next      = cnt_reg;
        div_next      = div_reg;
        cmd_next      = cmd_reg;
        wdata_next    = wdata_reg;
        nack_next     = nack_reg;
        rdata_next    = rsp_rdata_reg;
        rsp_nack_next = rsp_nack_reg;
        bus_err_next  = bus_err_reg;
        busy_next     = busy_reg;
        sda_oe_next   = sda_oe_reg;
        scl_oe_next   = scl_oe_reg;
        stretch_next  = '0;
        tick          = 1'b0;
        timeout       = 1'b0;

        active  = (state_reg == ST_START) || (state_reg == ST_BIT) ||
                  (state_reg == ST_ACK)   || (state_reg == ST_STOP);
        // Phase 2 follows an SCL release; a slave may still be holding SCL low.
        hold    = (STRETCH_EN != 0) && active && (phase_reg == 2'd2) && !scl_sync;
        illegal = (cmd[1] && cmd[0]) || ((cmd[1] || cmd[0]) && !busy_reg && !cmd[3]);

        if (hold) begin
            stretch_next = stretch_reg + 32'd1;
            timeout      = (STRETCH_TO != 0) && (stretch_next == STRETCH_LIM);
        end

        if (active && !hold) begin
            if (cnt_reg == div_reg) begin
                cnt_next = '0;
                tick     = 1'b1;
            end else begin
                cnt_next = cnt_reg + DIV_W'(1);
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_next      = cmd;
                    wdata_next    = cmd_wdata;
                    nack_next     = cmd_nack;
                    div_next      = clk_div;
                    cnt_next      = '0;
                    phase_next    = '0;
                    bit_next      = '0;
                    rsp_nack_next = 1'b0;
                    if (illegal) begin
                        bus_err_next = 1'b1;
                        state_next   = ST_DONE;
                    end else if (cmd[3]) begin
                        state_next = ST_START;
                    end else if (cmd[1] || cmd[0]) begin
                        state_next = ST_BIT;
                    end else if (cmd[2] && busy_reg) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_START: begin
                // Same four steps serve a first START (lines already released) and a repeated START.
                if (tick) begin
                    case (phase_reg)
                        2'd0: sda_oe_next = 1'b0;
                        2'd1: scl_oe_next = 1'b0;
                        2'd2: begin
                            sda_oe_next = 1'b1;
                            busy_next   = 1'b1;
                        end
                        default: begin
                            scl_oe_next = 1'b1;
                            if (cmd_reg[1] || cmd_reg[0])
                                state_next = ST_BIT;
                            else if (cmd_reg[2])
                                state_next = ST_STOP;
                            else
                                state_next = ST_DONE;
                        end
                    endcase
                end
            end
            ST_BIT: begin
                if (tick) begin
                    case (phase_reg)
                        2'd0: sda_oe_next = cmd_reg[0] ? ~wdata_reg[7] : 1'b0;
                        2'd1: scl_oe_next = 1'b0;
                        2'd2: if (cmd_reg[1]) rdata_next = {rsp_rdata_reg[6:0], sda_sync};
                        default: begin
                            scl_oe_next = 1'b1;
                            wdata_next  = {wdata_reg[6:0], 1'b0};
                            bit_next    = bit_reg + 3'd1;
                            if (bit_reg == 3'd7)
                                state_next = ST_ACK;
                        end
                    endcase
                end
            end
            ST_ACK: begin
                if (tick) begin
                    case (phase_reg)
                        2'd0: sda_oe_next = cmd_reg[1] ? ~nack_reg : 1'b0;
                        2'd1: scl_oe_next = 1'b0;
                        2'd2: if (cmd_reg[0]) rsp_nack_next = sda_sync;
                        default: begin
                            scl_oe_next = 1'b1;
                            state_next  = cmd_reg[2] ? ST_STOP : ST_DONE;
                        end
                    endcase
                end
            end
            ST_STOP: begin
                if (tick) begin
                    case (phase_reg)
                        2'd0: sda_oe_next = 1'b1;
                        2'd1: scl_oe_next = 1'b0;
                        2'd3: begin
                            sda_oe_next = 1'b0;
                            busy_next   = 1'b0;
                            state_next  = ST_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (tick)
            phase_next = phase_reg + 2'd1;

        // A stuck stretch abandons the transfer without a STOP and frees the bus.
        if (timeout) begin
            state_next   = ST_IDLE;
            sda_oe_next  = 1'b0;
            scl_oe_next  = 1'b0;
            busy_next    = 1'b0;
            bus_err_next = 1'b1;
            stretch_next = '0;
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_DONE);
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_nack  = rsp_nack_reg;
    assign bus_err   = bus_err_reg;
    assign busy      = busy_reg;
    assign sda_oe    = sda_oe_reg;
    assign scl_oe    = scl_oe_reg;

endmodule
